// File: rtl/cpu_bus.sv
// CPU-side bus for an NES-style system: CPU clock-enable generation, address decode,
// 2 KB work RAM, PPU register port, controller shift registers and sprite DMA.
module cpu_bus #(
  parameter int unsigned CE_DIV = 14,
  parameter bit          PRG16  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        cpu_ce,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_r,
  input  logic        cpu_w,
  output logic [7:0]  cpu_i,
  output logic [14:0] prg_a,
  input  logic [7:0]  prg_q,
  output logic [2:0]  ppu_a,
  output logic [7:0]  ppu_d,
  input  logic [7:0]  ppu_q,
  output logic        ppu_r,
  output logic        ppu_w,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        oam_w,
  input  logic [7:0]  joy1,
  input  logic [7:0]  joy2
);

  localparam int unsigned CW        = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int unsigned RAM_DEPTH = 2048;
  localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CE_DIV - 2);

  typedef enum logic [2:0] {IDLE, ALIGN, ALIGN2, READ, WRITE} dma_state_t;
  typedef enum logic [2:0] {SRC_ZERO, SRC_RAM, SRC_PPU, SRC_JOY1, SRC_JOY2, SRC_PRG} src_t;

  logic [CW-1:0] cnt;
  logic          parity;
  dma_state_t    state;
  logic [7:0]    page, idx, dma_data;
  logic [7:0]    ram [RAM_DEPTH];
  logic [7:0]    ram_q;
  src_t          src, src_q;
  logic          strobe;
  logic [7:0]    sr1, sr2;
  logic [15:0]   bus_a;
  logic          slot_end, pre_end, idle, ppu_sel, acc_r, acc_w;

  assign slot_end = (cnt == CNT_LAST);
  assign pre_end  = (cnt == CNT_PRE);
  assign idle     = (state == IDLE);
  assign ppu_sel  = (cpu_a[15:13] == 3'b001);
  // a CPU access happens on the clock where cpu_ce is high; write wins over read
  assign acc_w    = cpu_ce & cpu_w;
  assign acc_r    = cpu_ce & cpu_r & ~cpu_w;

  assign bus_a = idle ? cpu_a : {page, idx};
  assign prg_a = PRG16 ? {1'b0, bus_a[13:0]} : bus_a[14:0];

  // DMA never sees PPU, pad or open-bus sources
  always_comb begin
    src = SRC_ZERO;
    if (bus_a[15])                  src = SRC_PRG;
    else if (bus_a[15:13] == 3'b000) src = SRC_RAM;
    else if (idle) begin
      if (bus_a[15:13] == 3'b001)   src = SRC_PPU;
      else if (bus_a == 16'h4016)   src = SRC_JOY1;
      else if (bus_a == 16'h4017)   src = SRC_JOY2;
    end
  end

  // slot counter, CPU enable and PPU strobes, all timed to the last clock of a slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      parity <= 1'b0;
      cpu_ce <= 1'b0;
      ppu_r  <= 1'b0;
      ppu_w  <= 1'b0;
      ppu_a  <= '0;
      ppu_d  <= '0;
    end else begin
      cnt    <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) parity <= ~parity;
      cpu_ce <= pre_end & idle;
      ppu_r  <= pre_end & idle & ppu_sel & cpu_r & ~cpu_w;
      ppu_w  <= pre_end & idle & ppu_sel & cpu_w;
      ppu_a  <= cpu_a[2:0];
      ppu_d  <= cpu_d;
    end
  end

  // work RAM, contents survive reset
  always_ff @(posedge clock) begin
    if (acc_w && cpu_a[15:13] == 3'b000) ram[cpu_a[10:0]] <= cpu_d;
    ram_q <= ram[bus_a[10:0]];
  end

  // read mux: source select is aligned with the 1-clock RAM/PRG latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= SRC_ZERO;
      cpu_i <= '0;
    end else begin
      src_q <= src;
      case (src_q)
        SRC_RAM:  cpu_i <= ram_q;
        SRC_PPU:  cpu_i <= ppu_q;
        SRC_JOY1: cpu_i <= {7'b0100000, sr1[0]};
        SRC_JOY2: cpu_i <= {7'b0100000, sr2[0]};
        SRC_PRG:  cpu_i <= prg_q;
        default:  cpu_i <= '0;
      endcase
    end
  end

  // controller ports: reload while strobe is high, shift in ones on each read otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe <= 1'b0;
      sr1    <= 8'hFF;
      sr2    <= 8'hFF;
    end else begin
      if (acc_w && cpu_a == 16'h4016) strobe <= cpu_d[0];
      if (strobe) begin
        sr1 <= joy1;
        sr2 <= joy2;
      end else begin
        if (acc_r && cpu_a == 16'h4016) sr1 <= {1'b1, sr1[7:1]};
        if (acc_r && cpu_a == 16'h4017) sr2 <= {1'b1, sr2[7:1]};
      end
    end
  end

  // sprite DMA: optional alignment slot, then 256 read/write slot pairs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      page     <= '0;
      idx      <= '0;
      dma_data <= '0;
      oam_w    <= 1'b0;
      oam_a    <= '0;
      oam_d    <= '0;
    end else begin
      oam_w <= pre_end & (state == WRITE);
      oam_a <= idx;
      oam_d <= dma_data;
      case (state)
        IDLE: if (acc_w && cpu_a == 16'h4014) begin
          state <= ALIGN;
          page  <= cpu_d;
          idx   <= '0;
        end
        ALIGN:  if (slot_end) state <= parity ? ALIGN2 : READ;
        ALIGN2: if (slot_end) state <= READ;
        READ: if (slot_end) begin
          dma_data <= cpu_i;
          state    <= WRITE;
        end
        WRITE: if (slot_end) begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus.sv
// Directed bench for cpu_bus: enable timing, decode, pads, PPU strobes and sprite DMA.
module tb_cpu_bus;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_ce;
  logic [15:0] cpu_a = '0;
  logic [7:0]  cpu_d = '0;
  logic        cpu_r = 1'b0;
  logic        cpu_w = 1'b0;
  logic [7:0]  cpu_i;
  logic [14:0] prg_a;
  logic [7:0]  prg_q = '0;
  logic [2:0]  ppu_a;
  logic [7:0]  ppu_d;
  logic [7:0]  ppu_q = 8'hA7;
  logic        ppu_r, ppu_w;
  logic [7:0]  oam_a, oam_d;
  logic        oam_w;
  logic [7:0]  joy1 = '0;
  logic [7:0]  joy2 = '0;

  int checks = 0;
  int errors = 0;
  int cyc;
  int last_ce = 0;

  cpu_bus #(.CE_DIV(14), .PRG16(1'b0)) dut (
    .clock(clock), .reset(reset), .cpu_ce(cpu_ce),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_i(cpu_i),
    .prg_a(prg_a), .prg_q(prg_q),
    .ppu_a(ppu_a), .ppu_d(ppu_d), .ppu_q(ppu_q), .ppu_r(ppu_r), .ppu_w(ppu_w),
    .oam_a(oam_a), .oam_d(oam_d), .oam_w(oam_w),
    .joy1(joy1), .joy2(joy2)
  );

  always #5 clock = ~clock;

  // PRG ROM stand-in: data = low address byte + high address bits
  always @(posedge clock) prg_q <= prg_a[7:0] + {1'b0, prg_a[14:8]};

  // clocks since reset release; the slot index of a cpu_ce clock is cyc/14
  always @(posedge clock or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ce();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (cpu_ce !== 1'b1 && n < 100);
    if (cpu_ce !== 1'b1) check("ce_timeout", 0, 1);
    last_ce = cyc;
  endtask

  task automatic access(input logic [15:0] a, input logic [7:0] d, input bit r, input bit w,
                        output logic [7:0] q, output logic [2:0] st);
    cpu_a = a; cpu_d = d; cpu_r = r; cpu_w = w;
    wait_ce();
    q  = cpu_i;
    st = {ppu_r, ppu_w, oam_w};
    @(posedge clock); #1;
    cpu_r = 1'b0; cpu_w = 1'b0;
  endtask

  task automatic run_dma(input logic [7:0] page, input bit par, input int exp_slots,
                         input int abort_at);
    logic [7:0] q;
    logic [2:0] st;
    int n = 0, rd = 0, guard = 0, t0;
    // pick a write slot of the requested parity
    wait_ce();
    if (((last_ce / 14) % 2) == int'(par)) wait_ce();
    @(posedge clock); #1;
    access(16'h4014, page, 1'b0, 1'b1, q, st);
    t0 = last_ce;
    while (guard < 20000) begin
      @(negedge clock);
      guard++;
      if (ppu_r) rd++;
      if (oam_w) begin
        check("oam_a", oam_a, n);
        check("oam_d", oam_d, (page == 8'h02) ? n : 0);
        n++;
        if (n == abort_at) break;
      end
      if (cpu_ce) break;
    end
    if (abort_at == 0) begin
      check("dma_resume", cpu_ce, 1);
      check("dma_oam_count", n, 256);
      check("dma_stall_slots", (cyc - t0) / 14 - 1, exp_slots);
      check("dma_ppu_r", rd, 0);
      @(posedge clock); #1;
    end
  endtask

  bit pad_exp [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [7:0] q;
    logic [2:0] st;
    int pulses, extra, first;

    repeat (3) @(negedge clock);
    check("rst_cpu_ce", cpu_ce, 0);
    check("rst_strobes", {ppu_r, ppu_w, oam_w}, 0);
    check("rst_cpu_i", cpu_i, 0);
    reset = 1'b0;

    // first enables in the 14th, 28th, 42nd clock after release, one clock wide
    for (int k = 0; k < 3; k++) begin
      wait_ce();
      check("ce_cycle", last_ce, 14 * k + 13);
      @(negedge clock);
      check("ce_width", cpu_ce, 0);
    end

    access(16'h4016, 8'h00, 1'b1, 1'b0, q, st);
    check("pad_after_reset", q, 8'h41);

    access(16'h0805, 8'h5A, 1'b0, 1'b1, q, st);
    check("ram_wr_strobes", st, 0);
    access(16'h1805, 8'h00, 1'b1, 1'b0, q, st);
    check("ram_mirror_rd", q, 8'h5A);
    check("ram_rd_strobes", st, 0);

    // data must follow the address within two clocks without any read request
    cpu_a = 16'h8123;
    @(posedge clock); @(posedge clock); @(negedge clock);
    check("prg_a_passive", prg_a, 15'h0123);
    check("prg_passive", cpu_i, 8'h24);
    cpu_a = 16'h0005;
    @(posedge clock); @(posedge clock); @(negedge clock);
    check("ram_passive", cpu_i, 8'h5A);

    access(16'hC123, 8'h00, 1'b1, 1'b0, q, st);
    check("prg_rd", q, 8'h64);

    cpu_a = 16'h2002; cpu_r = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (ppu_r) begin
        pulses++;
        check("ppu_a_rd", ppu_a, 2);
        check("ppu_rd_data", cpu_i, 8'hA7);
      end
    end
    cpu_r = 1'b0;
    check("ppu_r_pulses", pulses, 1);

    access(16'h2005, 8'h3C, 1'b0, 1'b1, q, st);
    check("ppu_wr_strobes", st, 3'b010);
    check("ppu_d", ppu_d, 8'h3C);
    check("ppu_a_wr", ppu_a, 5);
    access(16'h2001, 8'h11, 1'b1, 1'b1, q, st);
    check("rw_is_write", st, 3'b010);

    access(16'h5000, 8'h99, 1'b0, 1'b1, q, st);
    access(16'h5000, 8'h00, 1'b1, 1'b0, q, st);
    check("open_bus", q, 0);

    joy1 = 8'b0000_0101;
    joy2 = 8'hFE;
    access(16'h4016, 8'h01, 1'b0, 1'b1, q, st);
    access(16'h4016, 8'h00, 1'b0, 1'b1, q, st);
    for (int i = 0; i < 9; i++) begin
      access(16'h4016, 8'h00, 1'b1, 1'b0, q, st);
      check("pad1_bit", q[0], pad_exp[i]);
      if (i == 0) check("pad1_upper", q[7:1], 7'b0100000);
    end
    access(16'h4017, 8'h00, 1'b1, 1'b0, q, st);
    check("pad2_first", q, 8'h40);

    for (int i = 0; i < 256; i++)
      access(16'h0200 + 16'(i), 8'(i), 1'b0, 1'b1, q, st);

    // write in an odd slot puts ALIGN in an even slot: no extra alignment slot
    run_dma(8'h02, 1'b1, 513, 0);
    run_dma(8'h02, 1'b0, 514, 0);
    run_dma(8'h20, 1'b1, 513, 0);

    // reset in the middle of the transfer
    run_dma(8'h02, 1'b1, 0, 100);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_oam_w", oam_w, 0);
    check("abort_cpu_ce", cpu_ce, 0);
    repeat (3) @(negedge clock);
    check("abort_cpu_i", cpu_i, 0);
    reset = 1'b0;
    extra = 0;
    first = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (oam_w) extra++;
      if (cpu_ce && first < 0) first = cyc;
    end
    check("abort_no_oam", extra, 0);
    check("abort_first_ce", first, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
